// File: rtl/arm_mem_pkg.sv
// ============================================================================
// Module      : arm_mem_pkg
// Description : Shared types and constants for the unified memory-port
//               arbiter (FSM states, grant encoding, full-word byte enable).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Choose a winner among the eligible requesters. When both are eligible,
    // prefer_i selects fetch; otherwise the data side wins. The caller only
    // uses the result when at least one side is eligible.
    function automatic grant_t pick_winner(input logic if_ok,
                                           input logic d_ok,
                                           input logic prefer_i);
        grant_t w;
        w = GNT_D;
        if (if_ok && d_ok) begin
            w = prefer_i ? GNT_I : GNT_D;
        end else if (if_ok) begin
            w = GNT_I;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified memory port between the instruction-fetch
//               and load/store paths. Captures the winning request, drives the
//               memory for MEM_LATENCY cycles and pulses the winner's ready in
//               the last cycle. Data beats fetch by default; defining
//               ARB_ROUND_ROBIN_EN alternates grants when both are pending.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    // load/store
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    // memory
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q,    we_d;
    logic [3:0]        be_q,    be_d;

    logic              grant_pt;
    logic              if_ok;
    logic              d_ok;
    logic              prefer_i;
    grant_t            winner;

`ifdef ARB_ROUND_ROBIN_EN
    grant_t            last_q, last_d;
`endif

    // State, latency counter and captured request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= GNT_D;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next state: count down while busy; at a grant point (idle, or the final
    // busy cycle) pick a winner. The requester finishing now is not eligible
    // on this edge, so the other side is granted directly with no bubble.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        be_d     = be_q;
        grant_pt = 1'b0;
        if_ok    = 1'b0;
        d_ok     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d   = last_q;
        prefer_i = (last_q == GNT_D);
`else
        prefer_i = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                grant_pt = 1'b1;
                if_ok    = if_req;
                d_ok     = d_req;
            end
            BUSY_I: begin
                if (cnt_q == '0) begin
                    grant_pt = 1'b1;
                    d_ok     = d_req;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BUSY_D: begin
                if (cnt_q == '0) begin
                    grant_pt = 1'b1;
                    if_ok    = if_req;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        winner = pick_winner(if_ok, d_ok, prefer_i);

        if (grant_pt) begin
            if (if_ok || d_ok) begin
                cnt_d = CNT_LOAD;
`ifdef ARB_ROUND_ROBIN_EN
                last_d = winner;
`endif
                if (winner == GNT_D) begin
                    state_d = BUSY_D;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    be_d    = d_be;
                end else begin
                    state_d = BUSY_I;
                    addr_d  = if_addr;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Memory strobes and ready/rdata; address and write data always reflect
    // the last captured request so they hold their value while idle.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        mem_be    = '0;
        if_ready  = 1'b0;
        d_ready   = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        case (state_q)
            BUSY_I: begin
                mem_be = BE_WORD;
                if (cnt_q == '0) begin
                    if_ready = 1'b1;
                    if_rdata = mem_rdata;
                end
            end
            BUSY_D: begin
                mem_we = we_q;
                mem_be = be_q;
                if (cnt_q == '0) begin
                    d_ready = 1'b1;
                    d_rdata = mem_rdata;
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Four instances with
//               MEM_LATENCY 1..4 share one stimulus stream; each is compared
//               every cycle against a transaction-level reference model.
//               Honours ARB_ROUND_ROBIN_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int NI = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] mem_rdata = '0;

    logic        o_ifr  [NI];
    logic        o_dr   [NI];
    logic [31:0] o_ifrd [NI];
    logic [31:0] o_drd  [NI];
    logic [31:0] o_addr [NI];
    logic [31:0] o_wdata[NI];
    logic        o_we   [NI];
    logic [3:0]  o_be   [NI];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mem_port_arbiter #(
                .MEM_LATENCY(g + 1),
                .ADDR_W     (32),
                .DATA_W     (32)
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .if_req   (if_req),
                .if_addr  (if_addr),
                .if_ready (o_ifr[g]),
                .if_rdata (o_ifrd[g]),
                .d_req    (d_req),
                .d_we     (d_we),
                .d_addr   (d_addr),
                .d_wdata  (d_wdata),
                .d_be     (d_be),
                .d_ready  (o_dr[g]),
                .d_rdata  (o_drd[g]),
                .mem_addr (o_addr[g]),
                .mem_we   (o_we[g]),
                .mem_be   (o_be[g]),
                .mem_wdata(o_wdata[g]),
                .mem_rdata(mem_rdata)
            );
        end
    endgenerate

    // ---------------- reference model (one access record per instance) ----
    bit          m_busy  [NI];
    bit          m_side_d[NI];
    int          m_left  [NI];   // cycles of the access still to run, incl. current
    logic [31:0] m_addr  [NI];
    logic [31:0] m_wdata [NI];
    bit          m_we    [NI];
    logic [3:0]  m_be    [NI];
    bit          m_last_d[NI];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [134:0] s_out[NI];

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            m_busy[k]   = 1'b0;
            m_side_d[k] = 1'b0;
            m_left[k]   = 0;
            m_addr[k]   = '0;
            m_wdata[k]  = '0;
            m_we[k]     = 1'b0;
            m_be[k]     = '0;
            m_last_d[k] = 1'b1;
        end
    endfunction

    // Layout: {if_ready, d_ready, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, d_rdata}
    function automatic logic [134:0] model_out(input int k);
        bit          fin, ifr, dr, we;
        logic [3:0]  be;
        fin = m_busy[k] && (m_left[k] == 1);
        ifr = fin && !m_side_d[k];
        dr  = fin && m_side_d[k];
        we  = m_busy[k] && m_side_d[k] && m_we[k];
        be  = !m_busy[k] ? 4'h0 : (m_side_d[k] ? m_be[k] : 4'hF);
        return {ifr, dr, we, be, m_addr[k], m_wdata[k],
                ifr ? mem_rdata : 32'h0, dr ? mem_rdata : 32'h0};
    endfunction

    function automatic logic [134:0] dut_out(input int k);
        return {o_ifr[k], o_dr[k], o_we[k], o_be[k], o_addr[k], o_wdata[k],
                o_ifrd[k], o_drd[k]};
    endfunction

    // Applies one clock edge to the model using the inputs presented at it.
    function automatic void model_edge();
        for (int k = 0; k < NI; k++) begin
            bit can_i, can_d, may_grant, take_d;
            can_i     = if_req;
            can_d     = d_req;
            may_grant = 1'b1;
            take_d    = 1'b0;
            if (m_busy[k]) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] > 0) begin
                    may_grant = 1'b0;
                end else begin
                    if (m_side_d[k]) can_d = 1'b0;
                    else             can_i = 1'b0;
                    m_busy[k] = 1'b0;
                end
            end
            if (may_grant && (can_i || can_d)) begin
                if (can_i && can_d) take_d = RR ? !m_last_d[k] : 1'b1;
                else                take_d = can_d;
                m_busy[k]   = 1'b1;
                m_side_d[k] = take_d;
                m_left[k]   = k + 1;
                m_last_d[k] = take_d;
                if (take_d) begin
                    m_addr[k]  = d_addr;
                    m_we[k]    = d_we;
                    m_be[k]    = d_be;
                    m_wdata[k] = d_wdata;
                end else begin
                    m_addr[k]  = if_addr;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [134:0] act, input logic [134:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare the current cycle, then let the clock edge happen.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            s_out[k] = dut_out(k);
            check($sformatf("model L=%0d cyc=%0d", k + 1, cyc), s_out[k], model_out(k));
        end
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++)
            check($sformatf("reset L=%0d", k + 1), dut_out(k), model_out(k));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    // ---------------- directed vectors for the MEM_LATENCY=1 instance ------
    typedef struct {
        bit          ir;
        logic [31:0] ia;
        bit          dq;
        bit          dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [3:0]  db;
        logic [31:0] rd;
        bit          e_ifr;
        bit          e_dr;
        bit          e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_ifrd;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int i_at, d_at, we_cnt, ifr_cnt, dr_cnt, first_side;
        logic [102:0] tact, texp;

        tbl[0] = '{1, 32'h40,  0, 0, 32'h0,   32'h0,        4'h0, 32'hE3A01005, 0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0};
        tbl[1] = '{0, 32'h40,  0, 0, 32'h0,   32'h0,        4'h0, 32'hE3A01005, 1, 0, 0, 4'hF, 32'h40,  32'hE3A01005, 32'h0};
        tbl[2] = '{0, 32'h0,   1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 32'h1111,     0, 0, 0, 4'h0, 32'h40,  32'h0,        32'h0};
        tbl[3] = '{1, 32'h44,  1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 32'h2222,     0, 1, 1, 4'h3, 32'h100, 32'h0,        32'h2222};
        tbl[4] = '{0, 32'h44,  1, 0, 32'h200, 32'h0,        4'hF, 32'h3333,     1, 0, 0, 4'hF, 32'h44,  32'h3333,     32'h0};
        tbl[5] = '{0, 32'h0,   0, 0, 32'h200, 32'h0,        4'hF, 32'h4444,     0, 1, 0, 4'hF, 32'h200, 32'h0,        32'h4444};
        tbl[6] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 32'h5555,     0, 0, 0, 4'h0, 32'h200, 32'h0,        32'h0};

        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if_req = tbl[i].ir; if_addr = tbl[i].ia; d_req = tbl[i].dq; d_we = tbl[i].dw;
            d_addr = tbl[i].da; d_wdata = tbl[i].dd; d_be = tbl[i].db; mem_rdata = tbl[i].rd;
            step();
            tact = {s_out[0][134:96], s_out[0][63:0]};
            texp = {tbl[i].e_ifr, tbl[i].e_dr, tbl[i].e_we, tbl[i].e_be, tbl[i].e_addr,
                    tbl[i].e_ifrd, tbl[i].e_drd};
            check($sformatf("table row %0d", i), {32'h0, tact}, {32'h0, texp});
        end

        // Store on MEM_LATENCY=3: strobe for exactly 3 cycles, ready in the 3rd.
        apply_reset();
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        step();
        d_req = 0;
        we_cnt = 0; d_at = -1; ifr_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            mem_rdata = $urandom;
            step();
            if (s_out[2][132] && s_out[2][131:128] == 4'b0011) we_cnt++;
            if (s_out[2][133] && d_at < 0) d_at = c;
            if (s_out[2][134]) ifr_cnt++;
        end
        check("store L3 we cycles", 135'(we_cnt), 135'(3));
        check("store L3 ready cycle", 135'(d_at), 135'(3));
        check("store L3 no if_ready", 135'(ifr_cnt), 135'(0));

        // Simultaneous requests on MEM_LATENCY=2.
        apply_reset();
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
        step();
        i_at = -1; d_at = -1;
        for (int c = 1; c <= 8; c++) begin
            mem_rdata = $urandom;
            step();
            if (s_out[1][133] && d_at < 0) begin d_at = c; d_req = 0; end
            if (s_out[1][134] && i_at < 0) begin i_at = c; if_req = 0; end
        end
        check("simul L2 d_ready cycle", 135'(d_at), 135'(RR ? 4 : 2));
        check("simul L2 if_ready cycle", 135'(i_at), 135'(RR ? 2 : 4));

        // Data request held continuously with a fetch pending, MEM_LATENCY=1.
        apply_reset();
        if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20; d_be = 4'hF;
        step();
        ifr_cnt = 0; dr_cnt = 0; first_side = -1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (s_out[0][134]) begin ifr_cnt++; if (first_side < 0) first_side = 0; end
            if (s_out[0][133]) begin dr_cnt++;  if (first_side < 0) first_side = 1; end
        end
        check("held d_req if_ready count", 135'(ifr_cnt), 135'(4));
        check("held d_req d_ready count", 135'(dr_cnt), 135'(4));
        check("held d_req first grant", 135'(first_side), 135'(RR ? 0 : 1));

        // Reset during the 2nd busy cycle of a store on MEM_LATENCY=4.
        apply_reset();
        d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h12345678; d_be = 4'hC;
        step();
        d_req = 0;
        step();
        check("L4 store active before reset", 135'(s_out[3][132]), 135'(1));
        #2;
        reset = 1'b1;
        #1;
        check("L4 async reset drops strobes", {132'h0, o_we[3], o_ifr[3], o_dr[3]}, 135'(0));
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        if_req = 1; if_addr = 32'h500;
        step();
        i_at = -1; dr_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            mem_rdata = $urandom;
            step();
            if (c == 1) if_req = 0;
            if (s_out[3][134] && i_at < 0) i_at = c;
            if (s_out[3][133]) dr_cnt++;
        end
        check("L4 fetch after reset cycle", 135'(i_at), 135'(4));
        check("L4 no d_ready after reset", 135'(dr_cnt), 135'(0));

        // Fetch request dropped right after grant on MEM_LATENCY=3.
        apply_reset();
        if_req = 1; if_addr = 32'h600;
        step();
        if_req = 0; if_addr = 32'hFFFF_FFF0;
        i_at = -1;
        for (int c = 1; c <= 5; c++) begin
            mem_rdata = $urandom;
            step();
            if (s_out[2][134] && i_at < 0) i_at = c;
        end
        check("L3 dropped fetch ready cycle", 135'(i_at), 135'(3));

        // Randomized traffic, including field changes while busy.
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) apply_reset();
            if_req    = ($urandom_range(0, 99) < 60);
            d_req     = ($urandom_range(0, 99) < 50);
            d_we      = $urandom_range(0, 1);
            if_addr   = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            d_be      = 4'($urandom);
            mem_rdata = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
